// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared constants and grant helper for the data-memory arbiter
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  // Port identifiers: port 0 is the core load/store path, port 1 is debug
  localparam logic c_ARB_PORT_CORE = 1'b0;
  localparam logic c_ARB_PORT_DBG  = 1'b1;
  localparam int   c_NUM_PORTS     = 2;

  // Grant vector for the current cycle. While locked, only the owner may be
  // granted; otherwise a single requester wins outright and a tie goes to prio.
  function automatic logic [1:0] arb_grant(
    input logic [1:0] req,
    input logic       locked,
    input logic       owner,
    input logic       prio
  );
    logic [1:0] g;
    g = 2'b00;
    if (locked) begin
      g[owner] = req[owner];
    end else if (req == 2'b11) begin
      g[prio] = 1'b1;
    end else begin
      g = req;
    end
    return g;
  endfunction

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port round-robin arbiter with RMW lock in front of the
//               single data-memory port; read data returns one cycle after
//               grant on the granted port.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  // port 0 (core)
  input  logic                  req0,
  input  logic                  we0,
  input  logic                  lock0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  // port 1 (debug / loader)
  input  logic                  req1,
  input  logic                  we1,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  // data memory
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Arbitration state
  logic r_prio;
  logic r_owner;
  logic r_locked;

  // Per-port read-return registers
  logic [c_NUM_PORTS-1:0] r_rvalid;
  logic [DATA_WIDTH-1:0]  r_rdata [c_NUM_PORTS];

  // Port signals gathered into vectors so both ports share one code path
  logic [c_NUM_PORTS-1:0] w_req;
  logic [c_NUM_PORTS-1:0] w_we;
  logic [c_NUM_PORTS-1:0] w_lock;
  logic [c_NUM_PORTS-1:0] w_gnt;
  logic                   w_any_gnt;
  logic                   w_gnt_port;

  assign w_req  = {req1, req0};
  assign w_we   = {we1, we0};
  assign w_lock = {lock1, lock0};

  assign w_gnt      = arb_grant(w_req, r_locked, r_owner, r_prio);
  assign w_any_gnt  = |w_gnt;
  assign w_gnt_port = w_gnt[1] ? c_ARB_PORT_DBG : c_ARB_PORT_CORE;

  assign gnt0    = w_gnt[0];
  assign gnt1    = w_gnt[1];
  assign rvalid0 = r_rvalid[0];
  assign rvalid1 = r_rvalid[1];
  assign rdata0  = r_rdata[0];
  assign rdata1  = r_rdata[1];

  // Steer the granted port onto the memory bus; an idle bus drives zeros
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_any_gnt) begin
      mem_read  = ~w_we[w_gnt_port];
      mem_write = w_we[w_gnt_port];
      mem_addr  = (w_gnt_port == c_ARB_PORT_DBG) ? addr1  : addr0;
      mem_wdata = (w_gnt_port == c_ARB_PORT_DBG) ? wdata1 : wdata0;
    end
  end

  // Round-robin priority and lock ownership; prio only moves on an unlocked
  // grant or on the grant that releases the lock
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio   <= c_ARB_PORT_CORE;
      r_owner  <= c_ARB_PORT_CORE;
      r_locked <= 1'b0;
    end else if (w_any_gnt) begin
      if (!r_locked) begin
        r_prio <= ~w_gnt_port;
        if (w_lock[w_gnt_port]) begin
          r_locked <= 1'b1;
          r_owner  <= w_gnt_port;
        end
      end else if (!w_lock[w_gnt_port]) begin
        r_locked <= 1'b0;
        r_prio   <= ~w_gnt_port;
      end
    end
  end

  // One read-return register set per port: rvalid pulses for one cycle after
  // a read grant, rdata holds until the next read on that port
  generate
    for (genvar i = 0; i < c_NUM_PORTS; i++) begin : g_port
      always_ff @(posedge clk) begin
        if (reset) begin
          r_rvalid[i] <= 1'b0;
          r_rdata[i]  <= '0;
        end else begin
          r_rvalid[i] <= w_gnt[i] & ~w_we[i];
          if (w_gnt[i] && !w_we[i]) begin
            r_rdata[i] <= mem_rdata;
          end
        end
      end
    end
  endgenerate

endmodule : dmem_arbiter
`default_nettype wire
